renkon_pool_max: RTL and testbench
==================================

Name: renkon_pool_max

Overview:
- Streaming 2x2 / stride-2 signed max-pooling stage, directly downstream of the per-pixel accumulator.
- Consumes the accumulated conv pixel stream in row-major order, one pixel per in_en cycle, and emits one pooled pixel per 2x2 window.
- Holds one half-width line buffer so a single pass of the map is enough; no backpressure, upstream never stalls.

Parameters:
- DWIDTH, 16, signed pixel width (from shared package).
- MAXIMG, 32, maximum feature-map width in pixels; must be even.
- LWIDTH, 6, width of img_size and the column counter; must satisfy 2**LWIDTH > MAXIMG.

Ports:
- clk  in  1  clock.
- xrst  in  1  asynchronous active-low reset.
- init  in  1  synchronous pulse: start of a new feature map; clears counters, samples img_size.
- img_size  in  LWIDTH  map width in pixels; even, 2..MAXIMG; sampled only on init.
- in_en  in  1  pixel_in valid this cycle.
- pixel_in  in  DWIDTH signed  accumulated pixel.
- out_en  out  1  pixel_out valid, single-cycle pulse per window.
- pixel_out  out  DWIDTH signed  pooled pixel.

Behaviour:
- Reset (xrst low, async): col=0, row parity=0, pair register=0, width register=0, out_en=0, pixel_out=0. Line buffer contents not reset, and need not be: every read is preceded by a write in the same map.
- State per accepted pixel (in_en=1): col counter 0..img_size-1; row parity bit toggles when col wraps from img_size-1 to 0. No height counter; rows repeat indefinitely until the next init.
- Even col: pair register <= pixel_in.
- Odd col, even row: linebuf[col>>1] <= max(pair, pixel_in).
- Odd col, odd row: pixel_out <= max(max(pair, pixel_in), linebuf[col>>1]); out_en <= 1 the following cycle.
- Latency: out_en/pixel_out are registered and valid exactly 1 cycle after the in_en cycle carrying the bottom-right pixel of a window. out_en is 0 every other cycle. pixel_out holds its value between pulses.
- All comparisons signed and full DWIDTH; output has no width growth and no saturation.
- in_en low: all state holds, out_en=0; gaps of any length are legal.
- init=1: col=0, parity=0, out_en=0 next cycle, width <= img_size. If in_en is high in the same cycle, init wins and that pixel is discarded. An init mid-map abandons the partial window with no output.
- img_size odd, 0, or greater than MAXIMG: undefined; not checked in RTL, flagged by a bench assertion.

Optional Feature:
- Macro RENKON_POOL_RELU_EN.
- Defined: pixel_out is clamped to 0 when the pooled max is negative (ReLU fused after pooling). Latency is unchanged.
- Undefined: pixel_out is the raw signed max.

Decomposition:
- renkon_pkg holds DWIDTH, MAXIMG, LWIDTH and the signed pixel typedef shared with the accumulator and conv stages.
- One sub-module: renkon_pool_linebuf, MAXIMG/2 x DWIDTH register array with 1 write port and 1 async read port, no reset.
- Counters, max logic and the output register stay in renkon_pool_max.

Test Plan:
- Width 4, row0 = 1,5,-3,2; row1 = 4,0,-7,-1, in_en held high -> out_en pulses after pixel 6 (value 5) and after pixel 8 (value 2); no other pulses.
- Same stream with in_en deasserted for 3 cycles between every pixel -> same values 5 and 2, each exactly 1 cycle after its triggering pixel.
- Width 2, window -3,-5 / -2,-9 -> pixel_out = -2 without RENKON_POOL_RELU_EN; 0 with it.
- Width 4, 4 rows of consecutive values 0..15 -> outputs 5, 7, 13, 15, confirming parity wrap across rows.
- init asserted together with in_en after 3 pixels of a map, then a full width-2 map 9,1 / 2,3 -> stale pixels ignored, single output 9.
- xrst asserted mid-row -> out_en and pixel_out drop to 0 immediately; after release and init, a width-2 map 7,7 / 7,8 yields 8.

Source files
------------

// File: rtl/renkon_pkg.sv
// Shared definitions for the renkon conv / accumulate / pool pipeline.
package renkon_pkg;

  localparam int unsigned DWIDTH  = 16;
  localparam int unsigned MAXIMG  = 32;
  localparam int unsigned LWIDTH  = 6;
  localparam int unsigned LBDEPTH = MAXIMG / 2;
  localparam int unsigned LBAW    = $clog2(LBDEPTH);

  typedef logic signed [DWIDTH-1:0] pixel_t;

  // Signed maximum of two pixels.
  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/renkon_pool_linebuf.sv
// Half-width line buffer for the 2x2 pooling stage: one write port and one
// asynchronous read port. Contents are not reset because each entry is
// always written on the top row of a window before it is read.
module renkon_pool_linebuf
  import renkon_pkg::*;
(
  input  logic            clk,
  input  logic            we_i,
  input  logic [LBAW-1:0] waddr_i,
  input  pixel_t          wdata_i,
  input  logic [LBAW-1:0] raddr_i,
  output pixel_t          rdata_c_o
);

  pixel_t mem_q [LBDEPTH];

  // Store the top-row pair maximum.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/renkon_pool_max.sv
// Streaming 2x2 / stride-2 signed max-pooling stage.
// Optional: define RENKON_POOL_RELU_EN to clamp negative pooled values to 0.
module renkon_pool_max
  import renkon_pkg::*;
(
  input  logic              clk,
  input  logic              xrst,
  input  logic              init,
  input  logic [LWIDTH-1:0] img_size,
  input  logic              in_en,
  input  pixel_t            pixel_in,
  output logic              out_en,
  output pixel_t            pixel_out
);

  logic [LWIDTH-1:0] col_q, col_d;
  logic [LWIDTH-1:0] width_q, width_d;
  logic              par_q, par_d;
  pixel_t            pair_q, pair_d;
  logic              out_en_q, out_en_d;
  pixel_t            pixel_out_q, pixel_out_d;

  logic              lb_we_c;
  logic [LBAW-1:0]   lb_addr_c;
  pixel_t            lb_rdata_c;
  pixel_t            top_max_c;
  pixel_t            pool_c;

  assign lb_addr_c = LBAW'(col_q >> 1);
  assign top_max_c = smax(pair_q, pixel_in);
  assign pool_c    = smax(top_max_c, lb_rdata_c);

  renkon_pool_linebuf u_linebuf (
    .clk       (clk),
    .we_i      (lb_we_c),
    .waddr_i   (lb_addr_c),
    .wdata_i   (top_max_c),
    .raddr_i   (lb_addr_c),
    .rdata_c_o (lb_rdata_c)
  );

  // Next-state: column/row tracking, pair capture, line-buffer write, pooled output.
  always_comb begin
    col_d       = col_q;
    width_d     = width_q;
    par_d       = par_q;
    pair_d      = pair_q;
    out_en_d    = 1'b0;
    pixel_out_d = pixel_out_q;
    lb_we_c     = 1'b0;
    if (init) begin
      col_d   = '0;
      par_d   = 1'b0;
      width_d = img_size;
    end else if (in_en) begin
      if (col_q == width_q - LWIDTH'(1)) begin
        col_d = '0;
        par_d = ~par_q;
      end else begin
        col_d = col_q + LWIDTH'(1);
      end
      if (!col_q[0]) begin
        pair_d = pixel_in;
      end else if (!par_q) begin
        lb_we_c = 1'b1;
      end else begin
        out_en_d = 1'b1;
`ifdef RENKON_POOL_RELU_EN
        pixel_out_d = pool_c[DWIDTH-1] ? pixel_t'(0) : pool_c;
`else
        pixel_out_d = pool_c;
`endif
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      col_q       <= '0;
      width_q     <= '0;
      par_q       <= 1'b0;
      pair_q      <= '0;
      out_en_q    <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      col_q       <= col_d;
      width_q     <= width_d;
      par_q       <= par_d;
      pair_q      <= pair_d;
      out_en_q    <= out_en_d;
      pixel_out_q <= pixel_out_d;
    end
  end

  assign out_en    = out_en_q;
  assign pixel_out = pixel_out_q;

endmodule

// File: tb/tb_renkon_pool_max.sv
// Directed bench for renkon_pool_max with an expected-value queue.
module tb_renkon_pool_max;
  import renkon_pkg::*;

  logic              clk = 1'b0;
  logic              xrst;
  logic              init;
  logic [LWIDTH-1:0] img_size;
  logic              in_en;
  pixel_t            pixel_in;
  logic              out_en;
  pixel_t            pixel_out;

  int     checks = 0;
  int     errors = 0;
  pixel_t exp_q[$];
  pixel_t frame[$];
  pixel_t last_out;

  int vals_a[16] = '{1, 5, -3, 2, 4, 0, -7, -1, 0, 0, 0, 0, 0, 0, 0, 0};
  int vals_b[16] = '{-3, -5, -2, -9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int vals_c[16] = '{10, 20, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int vals_d[16] = '{9, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int vals_e[16] = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int vals_f[16] = '{7, 7, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  renkon_pool_max dut (
    .clk       (clk),
    .xrst      (xrst),
    .init      (init),
    .img_size  (img_size),
    .in_en     (in_en),
    .pixel_in  (pixel_in),
    .out_en    (out_en),
    .pixel_out (pixel_out)
  );

  // Flag illegal map widths at every init.
  always @(posedge clk) begin
    if (xrst && init) begin
      checks++;
      assert (img_size[0] == 1'b0 && img_size >= LWIDTH'(2) && img_size <= LWIDTH'(MAXIMG))
      else begin
        errors++;
        $error("FAIL img_size observed %0d required even 2..%0d", img_size, MAXIMG);
      end
    end
  end

  task automatic check(input string tag, input logic [DWIDTH-1:0] obs,
                       input logic [DWIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic load(input int v[16], input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(pixel_t'(v[i]));
  endtask

  // Advance one clock and compare the registered outputs.
  task automatic cycle_check(input bit trig);
    @(posedge clk);
    #1;
    check("out_en", DWIDTH'(out_en), DWIDTH'(trig));
    if (trig && exp_q.size() > 0) last_out = exp_q.pop_front();
    check("pixel_out", pixel_out, last_out);
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    for (int i = 0; i < n; i++) cycle_check(1'b0);
  endtask

  task automatic do_init(input int w, input logic en, input pixel_t px);
    init     = 1'b1;
    img_size = LWIDTH'(w);
    in_en    = en;
    pixel_in = px;
    cycle_check(1'b0);
    init  = 1'b0;
    in_en = 1'b0;
  endtask

  // Reference: max of the 2x2 window whose bottom-right pixel is frame[idx].
  function automatic pixel_t win_max(input int w, input int idx);
    pixel_t m;
    pixel_t c4[4];
    c4[0] = frame[idx - w - 1];
    c4[1] = frame[idx - w];
    c4[2] = frame[idx - 1];
    c4[3] = frame[idx];
    m = c4[0];
    for (int k = 1; k < 4; k++) if (c4[k] > m) m = c4[k];
`ifdef RENKON_POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic run_map(input int w, input int gap);
    for (int idx = 0; idx < frame.size(); idx++) begin
      bit trig;
      trig = ((idx / w) % 2 == 1) && ((idx % w) % 2 == 1);
      in_en    = 1'b1;
      pixel_in = frame[idx];
      if (trig) exp_q.push_back(win_max(w, idx));
      cycle_check(trig);
      if (gap > 0) idle(gap);
    end
    in_en = 1'b0;
  endtask

  initial begin
    xrst     = 1'b0;
    init     = 1'b0;
    in_en    = 1'b0;
    img_size = '0;
    pixel_in = '0;
    last_out = '0;
    #12;
    check("reset_out_en", DWIDTH'(out_en), DWIDTH'(0));
    check("reset_pixel_out", pixel_out, '0);
    xrst = 1'b1;
    @(posedge clk);
    #1;

    // Width 4, back-to-back pixels: expect 5 then 2.
    do_init(4, 1'b0, '0);
    load(vals_a, 8);
    run_map(4, 0);
    idle(2);

    // Same stream with 3-cycle gaps.
    do_init(4, 1'b0, '0);
    run_map(4, 3);
    idle(1);

    // All-negative window.
    do_init(2, 1'b0, '0);
    load(vals_b, 4);
    run_map(2, 0);
    idle(1);

    // Width 4, four rows 0..15: expect 5, 7, 13, 15.
    do_init(4, 1'b0, '0);
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back(pixel_t'(i));
    run_map(4, 0);
    idle(1);

    // Init mid-map with a colliding pixel that must be discarded.
    do_init(4, 1'b0, '0);
    load(vals_c, 3);
    run_map(4, 0);
    do_init(2, 1'b1, pixel_t'(100));
    load(vals_d, 4);
    run_map(2, 0);
    idle(1);

    // Async reset right after an output pulse, mid-row.
    do_init(4, 1'b0, '0);
    load(vals_e, 6);
    run_map(4, 0);
    #2;
    xrst = 1'b0;
    #1;
    last_out = '0;
    exp_q.delete();
    check("xrst_out_en", DWIDTH'(out_en), DWIDTH'(0));
    check("xrst_pixel_out", pixel_out, '0);
    #3;
    xrst = 1'b1;
    @(posedge clk);
    #1;
    do_init(2, 1'b0, '0);
    load(vals_f, 4);
    run_map(2, 0);
    idle(2);

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL leftover_expected observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
